// File: rtl/p2s_rr_scheduler.sv
// p2s_rr_scheduler: round-robin arbiter feeding one shared
// MSB-first parallel-to-serial shifter with word framing.
module p2s_rr_scheduler #(
  parameter int   WIDTH    = 2,
  parameter int   N_REQ    = 2,
  parameter logic IDLE_BIT = 1'b0,
  localparam int  GW = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  localparam int  CW = $clog2(WIDTH)
) (
  input  logic               clk_sig,
  input  logic               reset_sig,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               serial_sig,
  output logic               serial_valid,
  output logic               word_start,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [GW-1:0]    last_q, last_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic             sig_q, sig_d;
  logic             sv_q, sv_d;
  logic             ws_q, ws_d;

  logic [GW-1:0]    win;
  logic [GW-1:0]    idx;
  logic             found;
  logic             accept_en;
  logic             accept;
  logic [WIDTH-1:0] word;

  // Rotating search for the first valid requester after last_q.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept_en = (state_q == S_IDLE) ||
                     ((state_q == S_SHIFT) && (cnt_q == LAST_BIT));
  assign accept    = accept_en && (|req_valid) && !reset_sig;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign word      = req_data[int'(win)*WIDTH +: WIDTH];

  // Next-state: load on accept, shift in SHIFT, drop to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    last_d  = last_q;
    gid_d   = gid_q;
    sig_d   = sig_q;
    sv_d    = sv_q;
    ws_d    = 1'b0;
    if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      sh_d    = {word[WIDTH-2:0], 1'b0};
      sig_d   = word[WIDTH-1];
      sv_d    = 1'b1;
      ws_d    = 1'b1;
      last_d  = win;
      gid_d   = win;
    end else if (state_q == S_SHIFT) begin
      if (cnt_q == LAST_BIT) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sh_d    = '0;
        sig_d   = IDLE_BIT;
        sv_d    = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sh_d  = sh_q << 1;
        sig_d = sh_q[WIDTH-1];
      end
    end
  end

  // State register; synchronous reset wins over everything.
  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      last_q  <= GW'(N_REQ - 1);
      gid_q   <= '0;
      sig_q   <= IDLE_BIT;
      sv_q    <= 1'b0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      sig_q   <= sig_d;
      sv_q    <= sv_d;
      ws_q    <= ws_d;
    end
  end

  assign serial_sig   = sig_q;
  assign serial_valid = sv_q;
  assign word_start   = ws_q;
  assign grant_id     = gid_q;
  assign busy         = (state_q == S_SHIFT);

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// tb_p2s_rr_scheduler: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_p2s_rr_scheduler;

  localparam int   W  = 4;
  localparam int   N  = 3;
  localparam int   GW = 2;
  localparam logic IB = 1'b0;

  logic           clk_sig = 1'b0;
  logic           reset_sig;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           serial_sig;
  logic           serial_valid;
  logic           word_start;
  logic [GW-1:0]  grant_id;
  logic           busy;

  p2s_rr_scheduler #(
    .WIDTH(W),
    .N_REQ(N),
    .IDLE_BIT(IB)
  ) dut (
    .clk_sig(clk_sig),
    .reset_sig(reset_sig),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .serial_sig(serial_sig),
    .serial_valid(serial_valid),
    .word_start(word_start),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk_sig = ~clk_sig;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of bits still to be shown.
  // A new word may only be granted once the queue is empty.
  bit            pend[$];
  logic          m_sig = IB;
  logic          m_sv  = 1'b0;
  logic          m_ws  = 1'b0;
  logic [GW-1:0] m_gid = '0;
  int            m_ptr = N - 1;
  bit            mchk  = 1'b0;

  function automatic logic [N-1:0] m_ready();
    int j;
    if (reset_sig || pend.size() != 0 || req_valid == '0)
      return '0;
    for (int k = 1; k <= N; k++) begin
      j = (m_ptr + k) % N;
      if (req_valid[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    int w;
    bit nw;
    r  = m_ready();
    w  = 0;
    nw = 1'b0;
    if (reset_sig) begin
      pend.delete();
      m_sig = IB;
      m_sv  = 1'b0;
      m_ws  = 1'b0;
      m_gid = '0;
      m_ptr = N - 1;
    end else begin
      if (r != '0) begin
        for (int i = 0; i < N; i++) if (r[i]) w = i;
        m_ptr = w;
        m_gid = GW'(w);
        for (int b = W - 1; b >= 0; b--)
          pend.push_back(req_data[w*W+b]);
        nw = 1'b1;
      end
      if (pend.size() > 0) begin
        m_sig = pend.pop_front();
        m_sv  = 1'b1;
        m_ws  = nw;
      end else begin
        m_sig = IB;
        m_sv  = 1'b0;
        m_ws  = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    chk("m_ready", 32'(req_ready), 32'(m_ready()));
    chk("m_sig", 32'(serial_sig), 32'(m_sig));
    chk("m_valid", 32'(serial_valid), 32'(m_sv));
    chk("m_start", 32'(word_start), 32'(m_ws));
    chk("m_gid", 32'(grant_id), 32'(m_gid));
    chk("m_busy", 32'(busy), 32'(m_sv));
  endtask

  task automatic to_neg();
    @(negedge clk_sig);
    if (mchk) model_check();
  endtask

  task automatic to_pos();
    @(posedge clk_sig);
    model_step();
    #1;
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   rdy;
    logic           sig;
    logic           sv;
    logic           ws;
    logic [GW-1:0]  gid;
    logic           bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic [N-1:0] v,
                     input logic [N*W-1:0] d,
                     input logic [N-1:0] rdy, input logic sig,
                     input logic sv, input logic ws,
                     input logic [GW-1:0] gid, input logic bsy);
    tbl.push_back('{rst, v, d, rdy, sig, sv, ws, gid, bsy});
  endtask

  logic [N-1:0] hs;
  int           wt[N];
  logic [N-1:0] gq[$];
  int           gc[$];

  initial begin
    reset_sig = 1'b1;
    req_valid = 3'b011;
    req_data  = 12'h00B;
    for (int i = 0; i < N; i++) wt[i] = 0;

    // reset held with requests pending
    for (int i = 0; i < 3; i++)
      row(1, 3'b011, 12'h00B, 3'b000, 0, 0, 0, 0, 0);
    // lone req0, word 1011
    row(0, 3'b001, 12'h00B, 3'b001, 0, 0, 0, 0, 0);
    row(0, 3'b000, 12'h00B, 3'b000, 1, 1, 1, 0, 1);
    row(0, 3'b000, 12'h00B, 3'b000, 0, 1, 0, 0, 1);
    row(0, 3'b000, 12'h00B, 3'b000, 1, 1, 0, 0, 1);
    row(0, 3'b000, 12'h00B, 3'b000, 1, 1, 0, 0, 1);
    row(0, 3'b000, 12'h00B, 3'b000, 0, 0, 0, 0, 0);
    // req0=A, req1=5 both held: alternate, gapless
    row(0, 3'b011, 12'h05A, 3'b010, 0, 0, 0, 0, 0);
    row(0, 3'b011, 12'h05A, 3'b000, 0, 1, 1, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 1, 1, 0, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 0, 1, 0, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b001, 1, 1, 0, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 1, 1, 1, 0, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 0, 1, 0, 0, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 1, 1, 0, 0, 1);
    row(0, 3'b011, 12'h05A, 3'b010, 0, 1, 0, 0, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 0, 1, 1, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 1, 1, 0, 1, 1);
    row(0, 3'b011, 12'h05A, 3'b000, 0, 1, 0, 1, 1);
    row(0, 3'b000, 12'h05A, 3'b000, 1, 1, 0, 1, 1);
    row(0, 3'b000, 12'h05A, 3'b000, 0, 0, 0, 1, 0);
    // req1 alone, F then 0 back to back
    row(0, 3'b010, 12'h0F0, 3'b010, 0, 0, 0, 1, 0);
    row(0, 3'b010, 12'h000, 3'b000, 1, 1, 1, 1, 1);
    row(0, 3'b010, 12'h000, 3'b000, 1, 1, 0, 1, 1);
    row(0, 3'b010, 12'h000, 3'b000, 1, 1, 0, 1, 1);
    row(0, 3'b010, 12'h000, 3'b010, 1, 1, 0, 1, 1);
    row(0, 3'b000, 12'h000, 3'b000, 0, 1, 1, 1, 1);
    row(0, 3'b000, 12'h000, 3'b000, 0, 1, 0, 1, 1);
    row(0, 3'b000, 12'h000, 3'b000, 0, 1, 0, 1, 1);
    row(0, 3'b000, 12'h000, 3'b000, 0, 1, 0, 1, 1);
    row(0, 3'b000, 12'h000, 3'b000, 0, 0, 0, 1, 0);

    to_pos();

    foreach (tbl[r]) begin
      reset_sig = tbl[r].rst;
      req_valid = tbl[r].v;
      req_data  = tbl[r].d;
      to_neg();
      chk($sformatf("vec%0d", r),
          32'({req_ready, serial_sig, serial_valid,
               word_start, grant_id, busy}),
          32'({tbl[r].rdy, tbl[r].sig, tbl[r].sv,
               tbl[r].ws, tbl[r].gid, tbl[r].bsy}));
      to_pos();
    end

    // reset two bits into a word, then priority restarts at req0
    reset_sig = 1'b0;
    req_valid = 3'b011;
    req_data  = 12'h05A;
    to_neg();
    chk("mid_grant", 32'(req_ready), 32'h1);
    to_pos();
    req_valid = 3'b010;
    to_neg();
    chk("mid_bit0", 32'({serial_sig, word_start}), 32'h3);
    to_pos();
    to_neg();
    chk("mid_bit1", 32'({serial_sig, serial_valid}), 32'h1);
    to_pos();
    reset_sig = 1'b1;
    to_neg();
    chk("rst_ready", 32'(req_ready), 32'h0);
    to_pos();
    reset_sig = 1'b0;
    req_valid = 3'b011;
    to_neg();
    chk("rst_flush",
        32'({serial_sig, serial_valid, busy, grant_id}),
        32'({IB, 1'b0, 1'b0, 2'd0}));
    chk("rst_first", 32'(req_ready), 32'h1);
    to_pos();
    req_valid = 3'b000;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      to_pos();
    end

    // three-way contention after req0 was last served
    req_valid = 3'b111;
    req_data  = 12'hC5A;
    for (int c = 0; c < 12; c++) begin
      to_neg();
      if (req_ready != '0) begin
        gq.push_back(req_ready);
        gc.push_back(c);
      end
      to_pos();
    end
    chk("rr3_count", 32'(gq.size()), 32'd3);
    if (gq.size() == 3) begin
      chk("rr3_g0", 32'({gq[0], 4'(gc[0])}), 32'h20);
      chk("rr3_g1", 32'({gq[1], 4'(gc[1])}), 32'h44);
      chk("rr3_g2", 32'({gq[2], 4'(gc[2])}), 32'h18);
    end
    req_valid = 3'b000;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      to_pos();
    end

    // random traffic against the model, with fairness bound
    mchk = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      reset_sig = ($urandom_range(0, 99) == 0);
      to_neg();
      hs = req_ready & req_valid;
      for (int i = 0; i < N; i++) begin
        if (reset_sig) wt[i] = 0;
        else if (hs[i]) chk($sformatf("fair%0d", i),
                            32'(wt[i] <= N * W), 32'd1);
        else if (req_valid[i]) wt[i]++;
      end
      to_pos();
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_data[i*W +: W] = W'($urandom);
          wt[i] = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
